// File: rtl/judge_hp_unit.sv
// ---------------------------------------------------------------------------
// judge_hp_unit
//   Answer-judging and hit-point engine for the two-player factorization game.
//   It checks the local player's factors against the current question with an
//   iterative shift-add multiplier and decides which player answered correctly
//   first. It also keeps both players' HP and reports judgement and HP status
//   back to the game controller.
//
//   Optional feature macro: HP_DRAW_DAMAGE_EN. When it is defined, entering
//   DRAW damages both players. When it is undefined, DRAW leaves HP unchanged.
//
// Ports
//   CLK        system clock
//   RST        synchronous active-high reset
//   STATE      controller state code
//   Q_VAL      current question N (2W bits)
//   FA, FB     local factors (W bits each)
//   SUBMIT     local answer strobe
//   REM_HIT    remote-correct pulse from the link
//   JUDG_OUT   00 none, 01 local first, 10 remote first, 11 simultaneous
//   WRONG_OUT  00 no local result, 01 local correct, 11 local incorrect
//   HP_OUT     00 both alive, 01 local HP zero, 10 remote HP zero
//   HP_LOC     local HP
//   HP_REM     remote HP
//   BUSY       multiplier running
// ---------------------------------------------------------------------------
module judge_hp_unit #(
    parameter int W       = 8,
    parameter int HPW     = 4,
    parameter int HP_INIT = 3,
    parameter int DMG     = 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [3:0]     STATE,
    input  logic [2*W-1:0] Q_VAL,
    input  logic [W-1:0]   FA,
    input  logic [W-1:0]   FB,
    input  logic           SUBMIT,
    input  logic           REM_HIT,
    output logic [1:0]     JUDG_OUT,
    output logic [1:0]     WRONG_OUT,
    output logic [1:0]     HP_OUT,
    output logic [HPW-1:0] HP_LOC,
    output logic [HPW-1:0] HP_REM,
    output logic           BUSY
);
    localparam logic [3:0] ST_READY    = 4'b0010;
    localparam logic [3:0] ST_QUESTION = 4'b0011;
    localparam logic [3:0] ST_INPUT    = 4'b0100;
    localparam logic [3:0] ST_DRAW     = 4'b0110;
    localparam logic [3:0] ST_WRONG    = 4'b0111;
    localparam logic [3:0] ST_GOOD     = 4'b1000;
    localparam logic [3:0] ST_OUCH     = 4'b1001;
    localparam logic [3:0] ST_WIN      = 4'b1010;
    localparam logic [3:0] ST_LOSE     = 4'b1011;

    localparam int             CW     = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);
    localparam logic [HPW-1:0] HP_RST = HPW'(HP_INIT);
    localparam logic [HPW-1:0] DMG_H  = HPW'(DMG);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_CMP} dp_state_e;

    dp_state_e      st_q, st_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W:0]   acc_q, acc_d;      // bit 2W is a sticky carry flag
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W-1:0] q_q, q_d;
    logic           triv_q, triv_d;    // a factor of 0 or 1 was entered
    logic [1:0]     judg_q, judg_d;
    logic [1:0]     wrong_q, wrong_d;
    logic [HPW-1:0] loc_q, loc_d, rem_q, rem_d;
    logic [1:0]     hpo_q, hpo_d;
    logic [3:0]     prev_q;

    logic           rem_ok, correct, entry, match_end;
    logic [2*W:0]   sum;

    function automatic logic [HPW-1:0] sat_dec(input logic [HPW-1:0] v);
        return (v < DMG_H) ? '0 : v - DMG_H;
    endfunction

    // ---------------- judging datapath ----------------
    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        q_d      = q_q;
        triv_d   = triv_q;
        judg_d   = judg_q;
        wrong_d  = wrong_q;

        rem_ok  = REM_HIT && (STATE == ST_QUESTION || STATE == ST_INPUT) && (judg_q == 2'b00);
        correct = (acc_q[2*W-1:0] == q_q) && !acc_q[2*W] && !triv_q;
        sum     = {1'b0, acc_q[2*W-1:0]} + {1'b0, mcand_q};

        if (rem_ok) judg_d = 2'b10;
        if (STATE == ST_WRONG && wrong_q == 2'b11) wrong_d = 2'b00;

        unique case (st_q)
            S_IDLE: begin
                if (SUBMIT && STATE == ST_INPUT && judg_q == 2'b00 && wrong_q != 2'b11) begin
                    st_d     = S_MUL;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {{W{1'b0}}, FA};
                    mplier_d = FB;
                    q_d      = Q_VAL;
                    triv_d   = (FA <= W'(1)) || (FB <= W'(1));
                end
            end
            S_MUL: begin
                if (mplier_q[0]) acc_d = {acc_q[2*W] | sum[2*W], sum[2*W-1:0]};
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) st_d = S_CMP;
            end
            S_CMP: begin
                st_d = S_IDLE;
                if (correct) begin
                    wrong_d = 2'b01;
                    // An already latched judgement is never overwritten.
                    if (judg_q == 2'b00) judg_d = rem_ok ? 2'b11 : 2'b01;
                end else begin
                    wrong_d = 2'b11;
                end
            end
            default: st_d = S_IDLE;
        endcase

        // A new round starts: drop any in-flight answer and clear the result.
        if (STATE == ST_READY) begin
            st_d    = S_IDLE;
            judg_d  = 2'b00;
            wrong_d = 2'b00;
        end
    end

    // ---------------- HP tracking ----------------
    always_comb begin
        loc_d     = loc_q;
        rem_d     = rem_q;
        hpo_d     = (loc_q == '0) ? 2'b01 : (rem_q == '0) ? 2'b10 : 2'b00;
        entry     = (STATE != prev_q);
        match_end = (prev_q == ST_WIN || prev_q == ST_LOSE) && STATE == ST_READY;

        if (entry) begin
            unique case (STATE)
                ST_GOOD: rem_d = sat_dec(rem_q);
                ST_OUCH: loc_d = sat_dec(loc_q);
                ST_DRAW: begin
`ifdef HP_DRAW_DAMAGE_EN
                    loc_d = sat_dec(loc_q);
                    rem_d = sat_dec(rem_q);
`endif
                end
                default: ;
            endcase
        end
        if (match_end) begin
            loc_d = HP_RST;
            rem_d = HP_RST;
            hpo_d = 2'b00;
        end
    end

    always_ff @(posedge CLK) begin
        // Tracking STATE through reset prevents a false entry on the first cycle.
        prev_q <= STATE;
        if (RST) begin
            st_q     <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            q_q      <= '0;
            triv_q   <= 1'b0;
            judg_q   <= 2'b00;
            wrong_q  <= 2'b00;
            loc_q    <= HP_RST;
            rem_q    <= HP_RST;
            hpo_q    <= 2'b00;
        end else begin
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            q_q      <= q_d;
            triv_q   <= triv_d;
            judg_q   <= judg_d;
            wrong_q  <= wrong_d;
            loc_q    <= loc_d;
            rem_q    <= rem_d;
            hpo_q    <= hpo_d;
        end
    end

    assign JUDG_OUT  = judg_q;
    assign WRONG_OUT = wrong_q;
    assign HP_OUT    = hpo_q;
    assign HP_LOC    = loc_q;
    assign HP_REM    = rem_q;
    assign BUSY      = (st_q != S_IDLE);

endmodule

// File: tb/tb_judge_hp_unit.sv
// Testbench for judge_hp_unit. Answer vectors come from a table. The expected
// judgement for each submit goes into a scoreboard queue when the submit is
// driven, and it is compared when the multiplier finishes. Hand-written
// sequences cover the multi-cycle corners: the resubmit after a wrong answer,
// HP entry and saturation, match reset, the simultaneous hit and reset
// mid-multiply.
module tb_judge_hp_unit;
    localparam logic [3:0] ST_READY    = 4'b0010;
    localparam logic [3:0] ST_QUESTION = 4'b0011;
    localparam logic [3:0] ST_INPUT    = 4'b0100;
    localparam logic [3:0] ST_DRAW     = 4'b0110;
    localparam logic [3:0] ST_WRONG    = 4'b0111;
    localparam logic [3:0] ST_GOOD     = 4'b1000;
    localparam logic [3:0] ST_OUCH     = 4'b1001;
    localparam logic [3:0] ST_WIN      = 4'b1010;
    localparam logic [3:0] ST_LOSE     = 4'b1011;

    logic        CLK = 1'b0;
    logic        RST, SUBMIT, REM_HIT;
    logic [3:0]  STATE;
    logic [15:0] Q_VAL;
    logic [7:0]  FA, FB;
    logic [1:0]  JUDG_OUT, WRONG_OUT, HP_OUT;
    logic [3:0]  HP_LOC, HP_REM;
    logic        BUSY;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  fa, fb;
        logic [1:0]  judg, wrong;
    } vec_t;
    typedef struct {
        logic [1:0] judg, wrong;
    } exp_t;

    vec_t tv[9];
    exp_t sb[$];

    judge_hp_unit dut (
        .CLK(CLK), .RST(RST), .STATE(STATE), .Q_VAL(Q_VAL), .FA(FA), .FB(FB),
        .SUBMIT(SUBMIT), .REM_HIT(REM_HIT), .JUDG_OUT(JUDG_OUT), .WRONG_OUT(WRONG_OUT),
        .HP_OUT(HP_OUT), .HP_LOC(HP_LOC), .HP_REM(HP_REM), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Submit one answer, then count the BUSY cycles. rem_cmp raises REM_HIT
    // in the compare cycle. mid_q moves STATE to QUESTION in the middle of
    // the multiply.
    task automatic run_submit(input logic [15:0] q, input logic [7:0] a, input logic [7:0] b,
                              input logic [1:0] ej, input logic [1:0] ew,
                              input bit rem_cmp, input bit mid_q);
        exp_t e;
        int   cnt;
        STATE = ST_INPUT; Q_VAL = q; FA = a; FB = b; SUBMIT = 1'b1;
        sb.push_back('{ej, ew});
        tick();
        SUBMIT = 1'b0;
        cnt = 0;
        while (BUSY && cnt < 40) begin
            cnt++;
            REM_HIT = rem_cmp && (cnt == 9);
            if (mid_q && cnt == 3) STATE = ST_QUESTION;
            tick();
            REM_HIT = 1'b0;
        end
        chk("busy_cycles", cnt, 9);
        e = sb.pop_front();
        chk("judg", JUDG_OUT, e.judg);
        chk("wrong", WRONG_OUT, e.wrong);
    endtask

    initial begin
        tv[0] = '{16'd221,   8'd13,  8'd17,  2'b01, 2'b01};
        tv[1] = '{16'd221,   8'd11,  8'd20,  2'b00, 2'b11};
        tv[2] = '{16'd221,   8'd1,   8'd221, 2'b00, 2'b11};
        tv[3] = '{16'd221,   8'd221, 8'd1,   2'b00, 2'b11};
        tv[4] = '{16'd65025, 8'd255, 8'd255, 2'b01, 2'b01};
        tv[5] = '{16'd4,     8'd2,   8'd2,   2'b01, 2'b01};
        tv[6] = '{16'd0,     8'd0,   8'd5,   2'b00, 2'b11};
        tv[7] = '{16'd143,   8'd11,  8'd13,  2'b01, 2'b01};
        tv[8] = '{16'd143,   8'd13,  8'd12,  2'b00, 2'b11};

        RST = 1'b1; SUBMIT = 1'b0; REM_HIT = 1'b0; STATE = ST_READY;
        Q_VAL = '0; FA = '0; FB = '0;
        tick(); tick();
        RST = 1'b0;
        chk("rst_judg", JUDG_OUT, 0);
        chk("rst_wrong", WRONG_OUT, 0);
        chk("rst_hpout", HP_OUT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_hploc", HP_LOC, 3);
        chk("rst_hprem", HP_REM, 3);

        // Table-driven answers. Each one starts from a fresh round.
        for (int i = 0; i < 9; i++) begin
            STATE = ST_READY; tick();
            run_submit(tv[i].q, tv[i].fa, tv[i].fb, tv[i].judg, tv[i].wrong, 1'b0, 1'b0);
        end

        // A wrong answer blocks a resubmit until WRONG clears it.
        STATE = ST_READY; tick();
        run_submit(16'd221, 8'd11, 8'd20, 2'b00, 2'b11, 1'b0, 1'b0);
        SUBMIT = 1'b1; tick(); SUBMIT = 1'b0;
        chk("resubmit_blocked_busy", BUSY, 0);
        STATE = ST_WRONG; tick();
        chk("wrong_cleared", WRONG_OUT, 0);
        run_submit(16'd221, 8'd13, 8'd17, 2'b01, 2'b01, 1'b0, 1'b0);

        // Entering GOOD once removes one HP, however long GOOD is held.
        STATE = ST_GOOD; tick();
        chk("good_hprem", HP_REM, 2);
        tick();
        chk("good_hold_hprem", HP_REM, 2);
        chk("good_hpout", HP_OUT, 0);

        // A trivial factor is rejected. REM_HIT counts only inside its window.
        STATE = ST_READY; tick();
        run_submit(16'd221, 8'd1, 8'd221, 2'b00, 2'b11, 1'b0, 1'b0);
        STATE = ST_WRONG; REM_HIT = 1'b1; tick(); REM_HIT = 1'b0;
        chk("remhit_outside_judg", JUDG_OUT, 0);
        chk("remhit_outside_wrong", WRONG_OUT, 0);
        STATE = ST_QUESTION; REM_HIT = 1'b1; tick(); REM_HIT = 1'b0;
        chk("remhit_judg", JUDG_OUT, 2);
        chk("remhit_wrong", WRONG_OUT, 0);
        STATE = ST_OUCH; tick();
        chk("ouch_hploc", HP_LOC, 2);

        // Simultaneous correct answers, then a state change in mid-multiply.
        STATE = ST_READY; tick();
        run_submit(16'd221, 8'd13, 8'd17, 2'b11, 2'b01, 1'b1, 1'b0);
        STATE = ST_READY; tick();
        run_submit(16'd143, 8'd11, 8'd13, 2'b01, 2'b01, 1'b0, 1'b1);

        // Remote HP goes to zero and saturates. WIN->READY reloads both HP.
        STATE = ST_READY; tick(); STATE = ST_GOOD; tick();
        chk("good2_hprem", HP_REM, 1);
        STATE = ST_READY; tick(); STATE = ST_GOOD; tick();
        chk("good3_hprem", HP_REM, 0);
        tick();
        chk("rem_zero_hpout", HP_OUT, 2);
        STATE = ST_READY; tick(); STATE = ST_GOOD; tick();
        chk("good_sat_hprem", HP_REM, 0);
        STATE = ST_WIN; tick(); STATE = ST_READY; tick();
        chk("win_reload_loc", HP_LOC, 3);
        chk("win_reload_rem", HP_REM, 3);
        chk("win_reload_hpout", HP_OUT, 0);
        tick();
        chk("win_reload_hpout_next", HP_OUT, 0);

        // Local HP goes to zero. LOSE->READY reloads both HP.
        for (int i = 0; i < 3; i++) begin
            STATE = ST_READY; tick(); STATE = ST_OUCH; tick();
        end
        chk("loc_zero_hploc", HP_LOC, 0);
        tick();
        chk("loc_zero_hpout", HP_OUT, 1);
        STATE = ST_LOSE; tick(); STATE = ST_READY; tick();
        chk("lose_reload_loc", HP_LOC, 3);
        chk("lose_reload_hpout", HP_OUT, 0);

        STATE = ST_DRAW; tick();
`ifdef HP_DRAW_DAMAGE_EN
        chk("draw_hploc", HP_LOC, 2);
        chk("draw_hprem", HP_REM, 2);
`else
        chk("draw_hploc", HP_LOC, 3);
        chk("draw_hprem", HP_REM, 3);
`endif

        // Reset in mid-multiply, then a SUBMIT outside INPUT.
        STATE = ST_READY; tick();
        STATE = ST_INPUT; Q_VAL = 16'd221; FA = 8'd13; FB = 8'd17; SUBMIT = 1'b1; tick();
        SUBMIT = 1'b0;
        chk("mid_busy", BUSY, 1);
        tick(); tick();
        RST = 1'b1; tick(); RST = 1'b0;
        chk("midrst_busy", BUSY, 0);
        chk("midrst_judg", JUDG_OUT, 0);
        chk("midrst_wrong", WRONG_OUT, 0);
        chk("midrst_hpout", HP_OUT, 0);
        chk("midrst_hploc", HP_LOC, 3);
        chk("midrst_hprem", HP_REM, 3);
        STATE = ST_QUESTION; SUBMIT = 1'b1; tick(); SUBMIT = 1'b0;
        chk("submit_outside_input", BUSY, 0);
        tick();
        chk("submit_outside_judg", JUDG_OUT, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/judge_hp_unit.md
Name: judge_hp_unit

Overview:
- Answer-judging and hit-point engine for the two-player factorization game. It is the producer side of the game controller's JUDG_IN / WRONG_IN / HP_IN interface.
- Consumes the controller's STATE, the current question value, the local player's two entered factors and a remote-correct strobe from the link.
- Checks the local answer with an iterative shift-add multiplier, arbitrates first-correct, tracks both players' HP and reports judgement/HP status back to the controller.

Parameters:
W, 8, factor width; the question is 2W bits
HPW, 4, HP counter width
HP_INIT, 3, HP loaded for both players at reset and at match end
DMG, 1, HP removed per lost round

Ports:
CLK  in  1  system clock
RST  in  1  reset, synchronous, active-high
STATE  in  4  controller state (READY=0010, QUESTION=0011, INPUT=0100, DRAW=0110, WRONG=0111, GOOD=1000, OUCH=1001, WIN=1010, LOSE=1011)
Q_VAL  in  2W  current question N
FA  in  W  local factor A
FB  in  W  local factor B
SUBMIT  in  1  local answer strobe, one cycle
REM_HIT  in  1  remote player answered correctly, one-cycle pulse
JUDG_OUT  out  2  00 none, 01 local first, 10 remote first, 11 simultaneous
WRONG_OUT  out  2  00 no local result, 01 local correct, 11 local incorrect
HP_OUT  out  2  00 both alive, 01 local HP zero, 10 remote HP zero
HP_LOC  out  HPW  local HP
HP_REM  out  HPW  remote HP
BUSY  out  1  multiplier running

Behaviour:
- Reset (RST=1 at a CLK edge) values:
  - JUDG_OUT=00, WRONG_OUT=00, HP_OUT=00, BUSY=0.
  - HP_LOC=HP_REM=HP_INIT.
  - Datapath FSM goes to IDLE; any multiply in flight is aborted.
- Datapath FSM states: IDLE, MUL, CMP.
  - IDLE->MUL: on SUBMIT=1 while STATE==INPUT and JUDG_OUT==00 and WRONG_OUT!=11. FA, FB and Q_VAL are captured, accumulator cleared, BUSY=1.
  - SUBMIT in any other case is ignored.
  - MUL: one multiplier bit per cycle, W cycles. Product is 2W bits; a carry out of bit 2W-1 forces the result incorrect.
  - MUL->CMP after W cycles.
  - CMP: correct iff product==captured Q and FA>1 and FB>1.
  - CMP->IDLE with BUSY=0.
- Latency: SUBMIT at cycle 0 -> outputs updated at the edge of cycle W+2.
- CMP outcomes:
  - Correct: WRONG_OUT=01. JUDG_OUT becomes 01, or 11 if REM_HIT=1 in the same cycle.
  - Incorrect: WRONG_OUT=11. JUDG_OUT is unchanged, except REM_HIT that cycle sets it to 10.
- REM_HIT: accepted only while STATE is QUESTION or INPUT and JUDG_OUT==00.
  - Sets JUDG_OUT=10, unless the CMP-correct same-cycle case above applies.
  - Pulses outside that window are dropped.
- Latching and clearing:
  - Once JUDG_OUT != 00 it holds, and further SUBMIT/REM_HIT are ignored until STATE==READY.
  - STATE==READY clears JUDG_OUT and WRONG_OUT to 00.
  - STATE==READY while in MUL or CMP aborts to IDLE.
  - STATE==WRONG clears WRONG_OUT 11->00. The controller must not re-enter WRONG on return to INPUT.
  - STATE leaving INPUT for QUESTION mid-MUL does not abort; the result is still reported.
- HP update: a registered previous-STATE copy detects state entry (STATE != prev).
  - Entry into GOOD: HP_REM -= DMG, saturating at 0.
  - Entry into OUCH: HP_LOC -= DMG, saturating at 0.
  - Entry into DRAW: see Optional Feature.
  - Only one decrement per entry, regardless of how long the state is held.
- HP_OUT is registered, one cycle after the HP change.
  - 01 if HP_LOC==0, else 10 if HP_REM==0, else 00. Local-zero has priority.
- Match end: transition WIN->READY or LOSE->READY reloads both HP to HP_INIT and sets HP_OUT=00 on the same edge.
- DMG > HP value: the counter clamps to 0 and never wraps.

Optional Feature:
- Macro HP_DRAW_DAMAGE_EN.
- Defined: entry into DRAW decrements both HP_LOC and HP_REM by DMG, saturating. Both reaching 0 reports HP_OUT=01.
- Undefined: DRAW leaves HP unchanged.

Test Plan:
- Q_VAL=221, FA=13, FB=17, SUBMIT in INPUT -> BUSY high 9 cycles; at cycle 10 JUDG_OUT=01, WRONG_OUT=01; HP_REM 3->2 one cycle after STATE=GOOD.
- Q_VAL=221, FA=11, FB=20 -> WRONG_OUT=11, JUDG_OUT=00; STATE=WRONG -> WRONG_OUT=00 next edge; a resubmit with 13×17 in INPUT then succeeds.
- FA=1, FB=221 -> WRONG_OUT=11 (trivial factor rejected); REM_HIT in QUESTION -> JUDG_OUT=10, WRONG_OUT=00; STATE=OUCH -> HP_LOC=2.
- REM_HIT asserted exactly in the CMP cycle of a correct answer -> JUDG_OUT=11, WRONG_OUT=01.
- Three GOOD entries -> HP_REM 3,2,1,0; HP_OUT=10; STATE WIN->READY -> HP_LOC=HP_REM=3, HP_OUT=00.
- RST mid-MUL -> BUSY=0 and all outputs at reset values next edge; a SUBMIT outside INPUT is ignored (BUSY stays 0).
